// File: rtl/reg_file_32x32_if.sv
// rtl/reg_file_32x32_if.sv - write/read bus and register-content taps of the 32x32 register file
interface reg_file_32x32_if;
  logic        WriteEn;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [4:0]  ReadAddrA;
  logic [4:0]  ReadAddrB;
  logic [31:0] RdA;
  logic [31:0] RdB;
  logic [15:0] WriteCount;
  logic [31:0] Reg00, Reg01, Reg02, Reg03, Reg04, Reg05, Reg06, Reg07;
  logic [31:0] Reg08, Reg09, Reg10, Reg11, Reg12, Reg13, Reg14, Reg15;
  logic [31:0] Reg16, Reg17, Reg18, Reg19, Reg20, Reg21, Reg22, Reg23;
  logic [31:0] Reg24, Reg25, Reg26, Reg27, Reg28, Reg29, Reg30, Reg31;

  modport master (
    output WriteEn, WriteAddr, WriteData, ReadAddrA, ReadAddrB,
    input  RdA, RdB, WriteCount,
    input  Reg00, Reg01, Reg02, Reg03, Reg04, Reg05, Reg06, Reg07,
    input  Reg08, Reg09, Reg10, Reg11, Reg12, Reg13, Reg14, Reg15,
    input  Reg16, Reg17, Reg18, Reg19, Reg20, Reg21, Reg22, Reg23,
    input  Reg24, Reg25, Reg26, Reg27, Reg28, Reg29, Reg30, Reg31
  );

  modport slave (
    input  WriteEn, WriteAddr, WriteData, ReadAddrA, ReadAddrB,
    output RdA, RdB, WriteCount,
    output Reg00, Reg01, Reg02, Reg03, Reg04, Reg05, Reg06, Reg07,
    output Reg08, Reg09, Reg10, Reg11, Reg12, Reg13, Reg14, Reg15,
    output Reg16, Reg17, Reg18, Reg19, Reg20, Reg21, Reg22, Reg23,
    output Reg24, Reg25, Reg26, Reg27, Reg28, Reg29, Reg30, Reg31
  );
endinterface

// File: rtl/reg_file_32x32.sv
// rtl/reg_file_32x32.sv - 32x32 register file, one write port, two combinational read ports
module reg_file_32x32 #(
  parameter bit          ZERO_R0   = 1'b1,
  parameter bit          BYPASS    = 1'b1,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic             Clk,
  input  logic             Reset,
  reg_file_32x32_if.slave  rf_io
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [15:0] wcnt_q;
  logic [15:0] wcnt_d;
  logic [31:0] wr_dec;
  logic        wr_active;
  logic [31:0] rd_a;
  logic [31:0] rd_b;

  assign wr_active = rf_io.WriteEn && !Reset;
  assign wr_dec    = rf_io.WriteEn ? (32'd1 << rf_io.WriteAddr) : 32'd0;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      // Register 0 keeps its reset zero when hardwired, but the write is still counted.
      if (wr_dec[i] && !(ZERO_R0 && i == 0)) begin
        regs_d[i] = rf_io.WriteData;
      end
    end
    wcnt_d = wcnt_q;
    if (rf_io.WriteEn && wcnt_q != 16'hFFFF) begin
      wcnt_d = wcnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (ZERO_R0 && i == 0) ? 32'd0 : RESET_VAL;
      end
      wcnt_q <= 16'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wcnt_q <= wcnt_d;
    end
  end

  always_comb begin
    rd_a = regs_q[rf_io.ReadAddrA];
    if (BYPASS && wr_active && rf_io.ReadAddrA == rf_io.WriteAddr) begin
      rd_a = (ZERO_R0 && rf_io.ReadAddrA == 5'd0) ? 32'd0 : rf_io.WriteData;
    end
  end

  always_comb begin
    rd_b = regs_q[rf_io.ReadAddrB];
    if (BYPASS && wr_active && rf_io.ReadAddrB == rf_io.WriteAddr) begin
      rd_b = (ZERO_R0 && rf_io.ReadAddrB == 5'd0) ? 32'd0 : rf_io.WriteData;
    end
  end

  assign rf_io.RdA        = rd_a;
  assign rf_io.RdB        = rd_b;
  assign rf_io.WriteCount = wcnt_q;

  // Content taps always show stored state, never the bypassed value.
  assign rf_io.Reg00 = regs_q[0];
  assign rf_io.Reg01 = regs_q[1];
  assign rf_io.Reg02 = regs_q[2];
  assign rf_io.Reg03 = regs_q[3];
  assign rf_io.Reg04 = regs_q[4];
  assign rf_io.Reg05 = regs_q[5];
  assign rf_io.Reg06 = regs_q[6];
  assign rf_io.Reg07 = regs_q[7];
  assign rf_io.Reg08 = regs_q[8];
  assign rf_io.Reg09 = regs_q[9];
  assign rf_io.Reg10 = regs_q[10];
  assign rf_io.Reg11 = regs_q[11];
  assign rf_io.Reg12 = regs_q[12];
  assign rf_io.Reg13 = regs_q[13];
  assign rf_io.Reg14 = regs_q[14];
  assign rf_io.Reg15 = regs_q[15];
  assign rf_io.Reg16 = regs_q[16];
  assign rf_io.Reg17 = regs_q[17];
  assign rf_io.Reg18 = regs_q[18];
  assign rf_io.Reg19 = regs_q[19];
  assign rf_io.Reg20 = regs_q[20];
  assign rf_io.Reg21 = regs_q[21];
  assign rf_io.Reg22 = regs_q[22];
  assign rf_io.Reg23 = regs_q[23];
  assign rf_io.Reg24 = regs_q[24];
  assign rf_io.Reg25 = regs_q[25];
  assign rf_io.Reg26 = regs_q[26];
  assign rf_io.Reg27 = regs_q[27];
  assign rf_io.Reg28 = regs_q[28];
  assign rf_io.Reg29 = regs_q[29];
  assign rf_io.Reg30 = regs_q[30];
  assign rf_io.Reg31 = regs_q[31];

endmodule

// File: doc/reg_file_32x32.md
Name: reg_file_32x32

Overview:
- 32-entry x 32-bit register file; the storage stage directly upstream of the 32:1 read multiplexers in the datapath.
- Exposes all 32 register contents as parallel buses, Reg00..Reg31, which connect straight into the mux data inputs. It also provides two internal read ports, RdA and RdB, built from the same selection logic.
- One synchronous write port with a 5-to-32 write decoder. Optional register-0-hardwired-zero and write-to-read bypass.

Parameters:
- ZERO_R0, 1, when 1: register 0 reads as 0 and ignores writes.
- BYPASS, 1, when 1: a read port whose address equals an active write address returns WriteData in the same cycle.
- RESET_VAL, 32'h00000000, value loaded into every register on reset.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- WriteEn  input  1  write strobe, sampled on rising Clk.
- WriteAddr  input  5  destination register index.
- WriteData  input  32  data to write.
- ReadAddrA  input  5  read port A index.
- ReadAddrB  input  5  read port B index.
- RdA  output  32  read port A data (combinational).
- RdB  output  32  read port B data (combinational).
- Reg00..Reg31  output  32 each  current register contents, feeding the 32:1 mux Data00..Data31.
- WriteCount  output  16  number of committed writes since reset; saturates at 16'hFFFF.

Behaviour:
- Clock and reset: one clock domain, Clk. Reset is asynchronous and active-high, named Reset.
- On Reset asserted, immediately and independent of Clk:
  - all 32 registers load RESET_VAL; register 0 loads 0 if ZERO_R0=1.
  - WriteCount clears to 0.
  - Reg00..Reg31, RdA and RdB reflect these values combinationally.
- While Reset is high:
  - writes are blocked.
  - a Reset assertion mid-cycle cancels any write pending for the next edge.
  - deassertion takes effect at the next rising Clk; the first write is possible on that edge.
- Write decoder: WriteAddr is one-hot decoded to 32 enables, gated by WriteEn.
- Write commit: on rising Clk with WriteEn=1 and Reset=0, register[WriteAddr] <= WriteData.
  - One-cycle latency: RegNN shows the new value after the edge.
- Writes to register 0 with ZERO_R0=1:
  - the data is discarded.
  - the write still counts as a committed write, i.e. WriteCount increments.
- WriteCount increments by exactly 1 per edge with WriteEn=1 and Reset=0. It holds at 16'hFFFF with no wrap-around.
- Read ports are combinational, with zero latency.
  - RdA = register[ReadAddrA]; RdB = register[ReadAddrB].
  - Full 5-bit decode; every address 0..31 is valid and no X output is permitted.
- Bypass (BYPASS=1):
  - if WriteEn=1 and ReadAddrX==WriteAddr, RdX = WriteData before the edge.
  - exception: when ZERO_R0=1 and the address is 0, RdX = 0.
  - Reg00..Reg31 are never bypassed; they always show stored state.
- With BYPASS=0, RdX shows the old value until the edge.
- Simultaneous reads: both ports may address the same register, and both may equal WriteAddr; each port resolves independently.
- No read-modify-write hazards; a single write port means no write-write conflict exists.
- All outputs are X-free after reset, for any input values.

Test Plan:
- Reset check: assert Reset for 2 cycles with RESET_VAL=32'h00000000, then release.
  -> All Reg00..Reg31=0, RdA=RdB=0, WriteCount=0.
  -> Reset asserted between edges clears the registers without a Clk edge.
- Write/readback: write reg k with 32'hA5A50000+k for k=1..31 in consecutive cycles, then sweep ReadAddrA 0..31 and ReadAddrB 31..0.
  -> Each RegNN and Rd port returns 32'hA5A50000+N; reg0 reads 0.
  -> WriteCount=31.
- Zero register: WriteEn=1, WriteAddr=0, WriteData=32'hFFFFFFFF.
  -> Reg00 stays 0, RdA(addr 0)=0 even with bypass, WriteCount increments by 1.
- Bypass: reg5=32'h11111111; drive WriteEn=1, WriteAddr=5, WriteData=32'h22222222, ReadAddrA=5, ReadAddrB=5.
  -> With BYPASS=1: RdA=RdB=32'h22222222 pre-edge while Reg05=32'h11111111.
  -> With BYPASS=0: RdA=32'h11111111 pre-edge.
  -> In both cases Reg05=32'h22222222 after the edge.
- Reset mid-operation: write reg7=32'hDEADBEEF, then pulse Reset asynchronously while WriteEn=1, WriteAddr=7.
  -> Reg07=0 and WriteCount=0 immediately.
  -> No write lands on an edge where Reset=1.
  -> After release, the next write lands normally.
- Saturation: force 65537 writes.
  -> WriteCount=16'hFFFF and holds; register contents remain correct.
